// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg
//   Shared definitions for the 1-to-N stream demultiplexer:
//   - sel_width(): select-index width for a channel count (at least 1 bit)
//   - reset values for per-channel slot state and the drop counter
//   - ch_lsb(): LSB of channel k within a flattened NUM_CH*DATA_W bus
package stream_demux_pkg;

  // Smallest w with 2**w >= n, never below 1 so a select port always exists.
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  localparam logic SLOT_VLD_RST  = 1'b0;
  localparam int   SLOT_DATA_RST = 0;
  localparam int   DROP_CNT_RST  = 0;

  function automatic int ch_lsb(input int k, input int data_w);
    return k * data_w;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot
//   One-entry registered holding slot for a single output channel.
//   Ports:
//     clk, rst     - clock, synchronous active-high reset
//     load         - write load_data this cycle (caller only asserts when free)
//     load_data    - beat to store
//     drain_ready  - consumer ready for this channel
//     valid, data  - slot contents; data is 0 whenever the slot is empty
//     free         - slot can take a beat this cycle (empty or draining)
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 2
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drain_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              free
);

  // Full-throughput slot: a draining slot can be refilled in the same cycle.
  assign free = ~valid | drain_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= SLOT_VLD_RST;
      data  <= DATA_W'(SLOT_DATA_RST);
    end else if (load) begin
      // Load wins over drain: a simultaneous drain+load keeps the slot full.
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid & drain_ready) begin
      valid <= 1'b0;
      data  <= DATA_W'(SLOT_DATA_RST);
    end
  end

endmodule

// File: rtl/stream_demux_1ton.sv
// stream_demux_1ton
//   Routes a valid/ready input stream to one of NUM_CH channels, selected
//   per beat by in_sel. Each channel owns a one-entry slot (demux_slot) so
//   backpressure on one consumer only stalls beats aimed at that channel.
//   Beats with in_sel >= NUM_CH are accepted and dropped; each drop raises
//   a one-cycle err_sel pulse and bumps a saturating drop_cnt.
//   Ports:
//     clk, rst               - clock, synchronous active-high reset
//     in_data/in_sel/in_valid/in_ready - input stream
//     out_data  [NUM_CH*DATA_W] - channel k at [k*DATA_W +: DATA_W]
//     out_valid/out_ready [NUM_CH] - per-channel handshake
//     err_sel                - drop pulse
//     drop_cnt  [CNT_W]      - saturating drop count
//   Build option DEMUX_BROADCAST_EN adds in_bcast: when high, a beat is
//   written into every slot at once (needs all slots free; in_sel ignored).
module stream_demux_1ton
  import stream_demux_pkg::*;
#(
  parameter  int DATA_W = 2,
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 8,
  localparam int SEL_W  = sel_width(NUM_CH)
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
`ifdef DEMUX_BROADCAST_EN
  input  logic                     in_bcast,
`endif
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic                     err_sel,
  output logic [CNT_W-1:0]         drop_cnt
);

  logic [NUM_CH-1:0]      free;
  logic [NUM_CH-1:0]      load;
  logic [(1<<SEL_W)-1:0]  free_pad;
  logic                   sel_ok;
  logic                   bcast;
  logic                   accept;
  logic                   drop;

`ifdef DEMUX_BROADCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  assign sel_ok = int'(in_sel) < NUM_CH;

  // Pad the free vector to the full select range so in_sel can index it
  // directly when NUM_CH is not a power of two; padding is never used
  // because sel_ok steers those indices elsewhere.
  always_comb begin
    free_pad               = '0;
    free_pad[NUM_CH-1:0]   = free;
  end

  // Ready never looks at in_valid, so producers may wait on it safely.
  always_comb begin
    if (rst)          in_ready = 1'b0;
    else if (bcast)   in_ready = &free;
    else if (!sel_ok) in_ready = 1'b1;
    else              in_ready = free_pad[in_sel];
  end

  assign accept = in_valid & in_ready;
  assign drop   = accept & ~bcast & ~sel_ok;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign load[k] = accept & (bcast | (sel_ok & (in_sel == SEL_W'(k))));

    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk         (clk),
      .rst         (rst),
      .load        (load[k]),
      .load_data   (in_data),
      .drain_ready (out_ready[k]),
      .valid       (out_valid[k]),
      .data        (out_data[ch_lsb(k, DATA_W) +: DATA_W]),
      .free        (free[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sel  <= 1'b0;
      drop_cnt <= CNT_W'(DROP_CNT_RST);
    end else begin
      err_sel <= drop;
      if (drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_demux_1ton.sv
// tb_stream_demux_1ton
//   Two instances: A (4 channels, 8-bit counter) for routing, backpressure
//   and reset; B (3 channels, 2-bit counter) for out-of-range drops and
//   counter saturation. A channel-level model tracks slot occupancy and is
//   compared against both instances every negedge; directed literal checks
//   pin the model at key points.
module tb_stream_demux_1ton;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: DATA_W=2, NUM_CH=4, CNT_W=8
  logic [1:0] a_data, a_sel;
  logic       a_valid, a_ready, a_err, a_bcast;
  logic [7:0] a_odata, a_cnt;
  logic [3:0] a_ovalid, a_oready;

  // Instance B: DATA_W=2, NUM_CH=3, CNT_W=2
  logic [1:0] b_data, b_sel;
  logic       b_valid, b_ready, b_err, b_bcast;
  logic [5:0] b_odata;
  logic [1:0] b_cnt;
  logic [2:0] b_ovalid, b_oready;

  stream_demux_1ton #(.DATA_W(2), .NUM_CH(4), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_sel(a_sel),
    .in_valid(a_valid), .in_ready(a_ready),
`ifdef DEMUX_BROADCAST_EN
    .in_bcast(a_bcast),
`endif
    .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_oready),
    .err_sel(a_err), .drop_cnt(a_cnt)
  );

  stream_demux_1ton #(.DATA_W(2), .NUM_CH(3), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_sel(b_sel),
    .in_valid(b_valid), .in_ready(b_ready),
`ifdef DEMUX_BROADCAST_EN
    .in_bcast(b_bcast),
`endif
    .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_oready),
    .err_sel(b_err), .drop_cnt(b_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- channel-level model ----------------
  int nch  [2] = '{4, 3};
  int cmax [2] = '{255, 3};
  int mfull[2][4];
  int mbeat[2][4];
  int merr [2];
  int mcnt [2];
  bit started = 1'b0;

  function automatic bit ch_free(input int i, input int k, input logic [3:0] ordy);
    return (mfull[i][k] == 0) || ordy[k];
  endfunction

  function automatic bit exp_rdy(input int i, input bit r, input int sel,
                                 input logic [3:0] ordy, input bit bc);
    bit all_free;
    if (r) return 1'b0;
    if (bc) begin
      all_free = 1'b1;
      for (int k = 0; k < nch[i]; k++) all_free &= ch_free(i, k, ordy);
      return all_free;
    end
    if (sel >= nch[i]) return 1'b1;
    return ch_free(i, sel, ordy);
  endfunction

  task automatic step(input int i, input bit r, input bit v, input int sel,
                      input int d, input logic [3:0] ordy, input bit bc);
    bit acc;
    acc = v && exp_rdy(i, r, sel, ordy, bc);
    if (r) begin
      for (int k = 0; k < 4; k++) begin mfull[i][k] = 0; mbeat[i][k] = 0; end
      merr[i] = 0;
      mcnt[i] = 0;
      return;
    end
    for (int k = 0; k < nch[i]; k++) begin
      if (acc && (bc || sel == k)) begin
        mfull[i][k] = 1; mbeat[i][k] = d;
      end else if (mfull[i][k] != 0 && ordy[k]) begin
        mfull[i][k] = 0; mbeat[i][k] = 0;
      end
    end
    merr[i] = (acc && !bc && sel >= nch[i]) ? 1 : 0;
    if (merr[i] != 0 && mcnt[i] < cmax[i]) mcnt[i]++;
  endtask

  function automatic logic [3:0] exp_ov(input int i);
    logic [3:0] v = '0;
    for (int k = 0; k < nch[i]; k++) v[k] = (mfull[i][k] != 0);
    return v;
  endfunction

  function automatic logic [7:0] exp_od(input int i);
    logic [7:0] v = '0;
    for (int k = 0; k < nch[i]; k++) v = v | (8'(mbeat[i][k]) << (2 * k));
    return v;
  endfunction

  always @(posedge clk) begin
    step(0, rst, a_valid, int'(a_sel), int'(a_data), a_oready, a_bcast);
    step(1, rst, b_valid, int'(b_sel), int'(b_data), {1'b0, b_oready}, b_bcast);
    if (rst) started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("a_in_ready",  a_ready,  exp_rdy(0, rst, int'(a_sel), a_oready, a_bcast));
      chk("a_out_valid", a_ovalid, exp_ov(0));
      chk("a_out_data",  a_odata,  exp_od(0));
      chk("a_err_sel",   a_err,    merr[0]);
      chk("a_drop_cnt",  a_cnt,    mcnt[0]);
      chk("b_in_ready",  b_ready,  exp_rdy(1, rst, int'(b_sel), {1'b0, b_oready}, b_bcast));
      chk("b_out_valid", b_ovalid, exp_ov(1));
      chk("b_out_data",  b_odata,  exp_od(1));
      chk("b_err_sel",   b_err,    merr[1]);
      chk("b_drop_cnt",  b_cnt,    mcnt[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b1; a_sel = 2'd0; a_data = 2'd1; a_oready = 4'hF; a_bcast = 1'b0;
    b_valid = 1'b1; b_sel = 2'd0; b_data = 2'd1; b_oready = 3'h7; b_bcast = 1'b0;

    // Reset held two cycles with in_valid high: nothing accepted.
    tick(); tick();
    chk("rst_in_ready", a_ready, 1'b0);
    chk("rst_out_valid", a_ovalid, 4'b0000);
    chk("rst_out_data", a_odata, 8'h00);
    chk("rst_drop_cnt", a_cnt, 8'd0);
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    tick();
    chk("post_rst_valid", a_ovalid, 4'b0000);

    // Unicast sweep, all consumers ready.
    a_valid = 1'b1; a_data = 2'b01; a_sel = 2'd0;
    tick(); chk("sweep0_v", a_ovalid, 4'b0001); chk("sweep0_d", a_odata, 8'h01);
    a_sel = 2'd3;
    tick(); chk("sweep3_v", a_ovalid, 4'b1000); chk("sweep3_d", a_odata, 8'h40);
    a_sel = 2'd2;
    tick(); chk("sweep2_v", a_ovalid, 4'b0100); chk("sweep2_d", a_odata, 8'h10);
    a_sel = 2'd1;
    tick(); chk("sweep1_v", a_ovalid, 4'b0010); chk("sweep1_d", a_odata, 8'h04);
    a_valid = 1'b0;
    tick(); chk("sweep_empty", a_ovalid, 4'b0000);

    // Backpressure on ch2, then drain+load in one cycle.
    a_oready = 4'b1011; a_valid = 1'b1; a_sel = 2'd2; a_data = 2'b10;
    #1 chk("bp_rdy_first", a_ready, 1'b1);
    tick(); chk("bp_held_v", a_ovalid, 4'b0100); chk("bp_held_d", a_odata, 8'h20);
    a_data = 2'b11;
    #1 chk("bp_stall", a_ready, 1'b0);
    tick(); chk("bp_still_d", a_odata, 8'h20);
    tick(); chk("bp_still_v", a_ovalid, 4'b0100);
    a_oready = 4'hF;
    #1 chk("bp_release", a_ready, 1'b1);
    tick(); chk("bp_nobubble_v", a_ovalid, 4'b0100); chk("bp_nobubble_d", a_odata, 8'h30);
    a_valid = 1'b0;
    tick(); chk("bp_drained", a_ovalid, 4'b0000);

    // Out-of-range on the 3-channel instance, with counter saturation.
    b_valid = 1'b1; b_sel = 2'd3; b_data = 2'd1;
    #1 chk("oor_ready", b_ready, 1'b1);
    tick(); chk("oor_err1", b_err, 1'b1); chk("oor_cnt1", b_cnt, 2'd1); chk("oor_nov", b_ovalid, 3'b000);
    tick(); chk("oor_cnt2", b_cnt, 2'd2);
    tick(); chk("oor_cnt3", b_cnt, 2'd3); chk("oor_err3", b_err, 1'b1);
    tick(); chk("oor_sat4", b_cnt, 2'd3);
    tick(); chk("oor_sat5", b_cnt, 2'd3);
    b_sel = 2'd2; b_data = 2'b11;
    tick(); chk("oor_err_end", b_err, 1'b0); chk("b_ch2_v", b_ovalid, 3'b100); chk("b_ch2_d", b_odata, 6'b110000);
    b_valid = 1'b0;
    tick();

    // Reset mid-operation discards full slots.
    a_oready = 4'h0; a_valid = 1'b1; a_sel = 2'd0; a_data = 2'b01;
    tick();
    a_sel = 2'd1; a_data = 2'b10;
    tick(); chk("mid_full_v", a_ovalid, 4'b0011); chk("mid_full_d", a_odata, 8'h09);
    a_valid = 1'b0; rst = 1'b1;
    tick(); chk("mid_rst_v", a_ovalid, 4'b0000); chk("mid_rst_d", a_odata, 8'h00);
    chk("mid_rst_bcnt", b_cnt, 2'd0);
    rst = 1'b0; a_valid = 1'b1; a_sel = 2'd3; a_data = 2'b11;
    tick(); chk("mid_after_v", a_ovalid, 4'b1000); chk("mid_after_d", a_odata, 8'hC0);
    a_valid = 1'b0; a_oready = 4'hF;
    tick();

`ifdef DEMUX_BROADCAST_EN
    // Broadcast blocked by one full, stalled channel.
    a_oready = 4'b1101; a_valid = 1'b1; a_sel = 2'd1; a_data = 2'b01;
    tick();
    a_bcast = 1'b1; a_data = 2'b11; a_sel = 2'd0;
    #1 chk("bc_blocked", a_ready, 1'b0);
    tick(); chk("bc_wait_v", a_ovalid, 4'b0010);
    a_oready = 4'hF;
    #1 chk("bc_ready", a_ready, 1'b1);
    tick(); chk("bc_all_v", a_ovalid, 4'b1111); chk("bc_all_d", a_odata, 8'hFF);
    a_valid = 1'b0; a_bcast = 1'b0;
    tick();
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_demux_1ton.md
Name: stream_demux_1toN

Overview:
- Parametrised successor to the team's fixed 2-bit 1-to-4 demultiplexer.
- Routes a valid/ready input stream of DATA_W-bit beats to one of NUM_CH output channels, chosen per beat by in_sel.
- Each channel has a one-entry registered holding slot, so output backpressure is absorbed per channel.
- Sits between a single producer and NUM_CH independent consumers.

Parameters:
- DATA_W, 2, beat width in bits (>=1).
- NUM_CH, 4, number of output channels (>=2; need not be a power of 2).
- CNT_W, 8, width of the saturating drop counter.
- SEL_W, derived localparam = clog2(NUM_CH); not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active high.
- in_data  input  DATA_W  input beat.
- in_sel  input  SEL_W  destination channel index for the current beat.
- in_valid  input  1  beat present.
- in_ready  output  1  beat accepted this cycle when high together with in_valid.
- out_data  output  NUM_CH*DATA_W  flattened; channel k occupies bits [k*DATA_W +: DATA_W].
- out_valid  output  NUM_CH  per-channel slot full.
- out_ready  input  NUM_CH  per-channel consumer ready.
- err_sel  output  1  one-cycle pulse: an out-of-range beat was dropped.
- drop_cnt  output  CNT_W  saturating count of dropped beats.

Behaviour:
- Reset: synchronous; on the rising clk edge with rst high, all outputs go to 0: out_valid, out_data, err_sel, drop_cnt. in_ready is combinationally 0 while rst is high.
- Reset mid-operation: pending slot contents are discarded. No beat is accepted in a reset cycle.
- Per-slot state: one valid bit plus a DATA_W data register.
  - Drain: a slot drains when out_valid[k] & out_ready[k].
  - Clear on drain: data register clears to 0 on drain. out_data for an empty channel is therefore always 0.
- in_ready, no reset, in_sel < NUM_CH: in_ready = ~out_valid[in_sel] | out_ready[in_sel]. This is combinational from in_sel, out_valid and out_ready, never from in_valid.
- in_ready, no reset, in_sel >= NUM_CH: in_ready = 1 (beat is sunk).
- Accept (in_valid & in_ready, valid index): slot[in_sel] loads in_data. out_valid[in_sel] = 1 on the next edge. Latency is 1 cycle; throughput is 1 beat/cycle.
- Simultaneous drain and load of the same slot: the slot stays valid and holds the new beat. No bubble.
- Drains of other channels in the same cycle are independent.
- Out-of-range accept:
  - No slot is written.
  - err_sel = 1 on the next cycle for exactly one cycle.
  - drop_cnt increments and saturates at 2^CNT_W-1; no wrap.
- Consumer side: out_ready may be high while out_valid is low, with no effect. A full slot holds its data stable until drained.
- No internal FSM beyond the per-slot valid bits. Global modes: RESET, RUN.

Optional Feature:
- Macro: DEMUX_BROADCAST_EN
- Defined:
  - Adds port in_bcast (input, 1 bit).
  - When in_bcast=1: in_ready = AND over k of (~out_valid[k] | out_ready[k]).
  - On accept, every slot loads in_data and all out_valid bits go to 1 next cycle. in_sel is ignored, and no drop or err_sel occurs.
  - When in_bcast=0: behaviour is unicast as above.
- Undefined: in_bcast port is absent; unicast only.

Decomposition:
- Shared package stream_demux_pkg holds:
  - clog2-style width function used for SEL_W.
  - Reset value constants for slot state and drop counter.
  - Channel-index helper for flattened bus slicing.
- Sub-module demux_slot:
  - One-entry register slice with ports clk, rst, load, load_data, drain_ready, valid, data, free.
  - Instantiated NUM_CH times by a generate loop.
  - Top level holds ready/select decode, error pulse and drop counter.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0000, out_data=0, drop_cnt=0; after release, no channel is valid.
- Unicast sweep (DATA_W=2, NUM_CH=4, out_ready=1111): in_data=01 with in_sel 0,3,2,1 on consecutive cycles -> one cycle later out_valid = 0001, 1000, 0100, 0010; out_data = 0x01, 0x40, 0x10, 0x04.
- Backpressure: out_ready[2]=0; send 10 to ch2, then 11 to ch2 -> the first beat is accepted, then in_ready=0 with out_data ch2=10 held. Raise out_ready[2] -> 10 drains and 11 loads in the same cycle with no bubble.
- Out-of-range (NUM_CH=3, SEL_W=2): send in_sel=3 three times -> in_ready=1, no out_valid, err_sel pulses 3 times, drop_cnt=3. With CNT_W=2, the 4th and 5th drops leave drop_cnt=3 (saturation).
- Reset mid-operation: ch0 and ch1 full with out_ready=0, assert rst for 1 cycle -> out_valid=0000 and out_data=0 next cycle; the next accepted beat appears alone.
- DEMUX_BROADCAST_EN: in_bcast=1 with ch1 full and out_ready[1]=0 -> in_ready=0. Release out_ready[1] -> beat 11 accepted; next cycle out_valid=1111 and every lane=11.
